// File: rtl/sdram_model_pkg.sv
// Shared types and constants for the SDR SDRAM pin-level responder.
// Holds the command encoding, bank state, error codes, legal CAS latencies,
// and the command decoder for {cs_n, ras_n, cas_n, we_n}.
package sdram_model_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_AUTO_REFRESH,
    CMD_LOAD_MODE,
    CMD_BURST_TERM
  } sdram_cmd_t;

  typedef enum logic {
    BANK_IDLE,
    BANK_OPEN
  } bank_state_t;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_CLOSED_BANK = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd3;
  localparam logic [2:0] ERR_BAD_MODE    = 3'd4;
  localparam logic [2:0] ERR_TRCD        = 3'd5;
  localparam logic [2:0] ERR_TRP         = 3'd6;
  localparam logic [2:0] ERR_COLLISION   = 3'd7;

  localparam logic [2:0] CL_2     = 3'd2;
  localparam logic [2:0] CL_3     = 3'd3;
  localparam logic [2:0] CL_RESET = CL_3;

  function automatic sdram_cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
    sdram_cmd_t c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACTIVE;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b010:  c = CMD_PRECHARGE;
        3'b001:  c = CMD_AUTO_REFRESH;
        3'b000:  c = CMD_LOAD_MODE;
        3'b110:  c = CMD_BURST_TERM;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl == CL_2) || (cl == CL_3);
  endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// Read-data pipeline: 3-deep shift register of valid, data and byte mask.
// Ports: clk/rst_n (async active-low), en (clock enable, freezes all stages
// when low), cancel (drops every in-flight entry), push_* (new entry from a
// READ command), dqm_in (live DQM pins), tap_cl3 (1: CL=3 tap, 0: CL=2 tap),
// out_* (entry due on DQ this cycle), pending (a read still owns the bus).
module sdram_read_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned MW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cancel,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  input  logic [MW-1:0] dqm_in,
  input  logic          tap_cl3,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [MW-1:0] out_mask,
  output logic          pending
);

  logic [2:0]    v;
  logic [DW-1:0] d [3];
  logic [MW-1:0] m [3];

  // Read DQM latency is 2: the mask is captured on the edge two cycles
  // before the data slot, i.e. into stage CL-2 (stage 0 for CL=2, stage 1
  // for CL=3), then carried along with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        d[i] <= '0;
        m[i] <= '0;
      end
    end else if (en) begin
      v[0] <= push_valid & ~cancel;
      d[0] <= push_data;
      m[0] <= dqm_in;
      v[1] <= v[0] & ~cancel;
      d[1] <= d[0];
      m[1] <= tap_cl3 ? dqm_in : m[0];
      v[2] <= v[1] & ~cancel;
      d[2] <= d[1];
      m[2] <= m[1];
    end
  end

  assign out_valid = tap_cl3 ? v[2] : v[1];
  assign out_data  = tap_cl3 ? d[2] : d[1];
  assign out_mask  = tap_cl3 ? m[2] : m[1];
  // Stage 2 is beyond the CL=2 tap, so it no longer counts as in flight.
  assign pending   = v[0] | v[1] | (tap_cl3 & v[2]);

endmodule

// File: rtl/sdram_chip_model.sv
// Cycle-level SDR SDRAM responder: 4 banks, x16, burst length 1.
// Decodes controller commands, tracks open rows, stores write data, and
// returns read data after the programmed CAS latency (2 or 3, reset 3).
// Ports: clk_clk, reset_reset_n (async active-low), sdram_wire_* (SDRAM pin
// interface; dq is driven only in a read data slot), err_valid/err_code
// (registered one-cycle violation report), err_sticky (OR of all reports).
// Build option: define SDRAM_MODEL_CHECK_EN to add per-bank tRCD/tRP
// checking (error codes 5 and 6).
module sdram_chip_model
  import sdram_model_pkg::*;
#(
  parameter int unsigned ROW_W  = 13,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned MEM_AW = 14,
  parameter int unsigned TRCD   = 2,
  parameter int unsigned TRP    = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [ROW_W-1:0] sdram_wire_addr,
  input  logic [1:0]       sdram_wire_ba,
  input  logic             sdram_wire_cs_n,
  input  logic             sdram_wire_ras_n,
  input  logic             sdram_wire_cas_n,
  input  logic             sdram_wire_we_n,
  input  logic             sdram_wire_cke,
  input  logic [1:0]       sdram_wire_dqm,
  inout  wire  [15:0]      sdram_wire_dq,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             err_sticky
);

  sdram_cmd_t       cmd;
  bank_state_t      bank_st  [4];
  logic [ROW_W-1:0] open_row [4];
  logic [2:0]       cl_q;
  logic [15:0]      mem [0:(1 << MEM_AW) - 1];

  logic              is_rd, is_wr, a10, bank_open, any_open;
  logic [MEM_AW-1:0] mem_idx;
  logic              trcd_bad, trp_bad;
  logic              err_now;
  logic [2:0]        err_code_now;

  logic        pipe_valid, pipe_pending, dq_oe;
  logic [15:0] pipe_data;
  logic [1:0]  pipe_mask;

  // A suspended clock (cke=0) decodes as NOP, which freezes every state update.
  always_comb begin
    cmd = CMD_NOP;
    if (sdram_wire_cke)
      cmd = decode_cmd(sdram_wire_cs_n, sdram_wire_ras_n, sdram_wire_cas_n, sdram_wire_we_n);
  end

  assign is_rd     = (cmd == CMD_READ);
  assign is_wr     = (cmd == CMD_WRITE);
  assign a10       = sdram_wire_addr[10];
  assign bank_open = (bank_st[sdram_wire_ba] == BANK_OPEN);
  assign mem_idx   = MEM_AW'({sdram_wire_ba, open_row[sdram_wire_ba], sdram_wire_addr[COL_W-1:0]});

  always_comb begin
    any_open = 1'b0;
    for (int unsigned b = 0; b < 4; b++)
      if (bank_st[b] == BANK_OPEN) any_open = 1'b1;
  end

  // Bank state and mode register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned b = 0; b < 4; b++) begin
        bank_st[b]  <= BANK_IDLE;
        open_row[b] <= '0;
      end
      cl_q <= CL_RESET;
    end else begin
      case (cmd)
        CMD_ACTIVE: begin
          bank_st[sdram_wire_ba]  <= BANK_OPEN;
          open_row[sdram_wire_ba] <= sdram_wire_addr;
        end
        CMD_PRECHARGE: begin
          for (int unsigned b = 0; b < 4; b++)
            if (a10 || (2'(b) == sdram_wire_ba)) bank_st[b] <= BANK_IDLE;
        end
        CMD_READ, CMD_WRITE: begin
          if (bank_open && a10) bank_st[sdram_wire_ba] <= BANK_IDLE;
        end
        CMD_LOAD_MODE: begin
          if (cl_legal(sdram_wire_addr[6:4])) cl_q <= sdram_wire_addr[6:4];
        end
        default: ;
      endcase
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_clk) begin
    if (is_wr && bank_open) begin
      if (!sdram_wire_dqm[0]) mem[mem_idx][7:0]  <= sdram_wire_dq[7:0];
      if (!sdram_wire_dqm[1]) mem[mem_idx][15:8] <= sdram_wire_dq[15:8];
    end
  end

`ifdef SDRAM_MODEL_CHECK_EN
  // Counters load with (tXX - 1) and count down to zero; nonzero at the
  // next command to that bank means the minimum spacing was not met.
  localparam logic [3:0] TRCD_LD = 4'(TRCD - 1);
  localparam logic [3:0] TRP_LD  = 4'(TRP - 1);

  logic [3:0] trcd_cnt [4];
  logic [3:0] trp_cnt  [4];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned b = 0; b < 4; b++) begin
        trcd_cnt[b] <= '0;
        trp_cnt[b]  <= '0;
      end
    end else if (sdram_wire_cke) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 4'd1;
        if (trp_cnt[b]  != '0) trp_cnt[b]  <= trp_cnt[b]  - 4'd1;
        if ((cmd == CMD_PRECHARGE) && (a10 || (2'(b) == sdram_wire_ba)))
          trp_cnt[b] <= TRP_LD;
      end
      if (cmd == CMD_ACTIVE) trcd_cnt[sdram_wire_ba] <= TRCD_LD;
      if ((is_rd || is_wr) && bank_open && a10) trp_cnt[sdram_wire_ba] <= TRP_LD;
    end
  end

  assign trcd_bad = (is_rd || is_wr) && bank_open && (trcd_cnt[sdram_wire_ba] != '0);
  assign trp_bad  = (cmd == CMD_ACTIVE) && (trp_cnt[sdram_wire_ba] != '0);
`else
  assign trcd_bad = 1'b0;
  assign trp_bad  = 1'b0;
`endif

  // Lowest error code wins when several apply to one command.
  always_comb begin
    err_code_now = ERR_NONE;
    if ((is_rd || is_wr) && !bank_open)
      err_code_now = ERR_CLOSED_BANK;
    else if ((cmd == CMD_ACTIVE) && bank_open)
      err_code_now = ERR_ACT_OPEN;
    else if ((cmd == CMD_AUTO_REFRESH) && any_open)
      err_code_now = ERR_REF_OPEN;
    else if ((cmd == CMD_LOAD_MODE) &&
             (!cl_legal(sdram_wire_addr[6:4]) || (sdram_wire_addr[2:0] != 3'b000)))
      err_code_now = ERR_BAD_MODE;
    else if (trcd_bad)
      err_code_now = ERR_TRCD;
    else if (trp_bad)
      err_code_now = ERR_TRP;
    else if (is_wr && pipe_pending)
      err_code_now = ERR_COLLISION;
    err_now = (err_code_now != ERR_NONE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_sticky <= 1'b0;
    end else begin
      err_valid <= err_now;
      err_code  <= err_code_now;
      if (err_now) err_sticky <= 1'b1;
    end
  end

  sdram_read_pipe #(
    .DW(16),
    .MW(2)
  ) u_read_pipe (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .en         (sdram_wire_cke),
    .cancel     (is_wr),
    .push_valid (is_rd && bank_open),
    .push_data  (mem[mem_idx]),
    .dqm_in     (sdram_wire_dqm),
    .tap_cl3    (cl_q == CL_3),
    .out_valid  (pipe_valid),
    .out_data   (pipe_data),
    .out_mask   (pipe_mask),
    .pending    (pipe_pending)
  );

  // A WRITE on the pins releases the bus in the same cycle; its edge then
  // cancels whatever reads were still in flight.
  assign dq_oe = pipe_valid && !is_wr;

  assign sdram_wire_dq[7:0]  = (dq_oe && !pipe_mask[0]) ? pipe_data[7:0]  : 'z;
  assign sdram_wire_dq[15:8] = (dq_oe && !pipe_mask[1]) ? pipe_data[15:8] : 'z;

endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed self-checking bench for sdram_chip_model.
// Commands are presented before a rising edge T and captured at T. Outputs
// are sampled on the falling edge; the data slot for a CL=n read is the
// half-period ending at edge T+n. The data bus is pulled up, so a released
// byte reads back as 8'hFF.
module tb_sdram_chip_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [1:0]  dqm;
  tri1  [15:0] dq;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        err_sticky;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

`ifdef SDRAM_MODEL_CHECK_EN
  localparam logic [2:0] EXP_TRCD = 3'd5;
  localparam logic [2:0] EXP_TRP  = 3'd6;
`else
  localparam logic [2:0] EXP_TRCD = 3'd0;
  localparam logic [2:0] EXP_TRP  = 3'd0;
`endif

  localparam logic [15:0] HIZ = 16'hFFFF;

  assign dq = tb_dq_en ? tb_dq : 'z;

  always #5 clk = ~clk;

  sdram_chip_model #(
    .ROW_W (13),
    .COL_W (10),
    .MEM_AW(14),
    .TRCD  (2),
    .TRP   (2)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .sdram_wire_addr  (addr),
    .sdram_wire_ba    (ba),
    .sdram_wire_cs_n  (cs_n),
    .sdram_wire_ras_n (ras_n),
    .sdram_wire_cas_n (cas_n),
    .sdram_wire_we_n  (we_n),
    .sdram_wire_cke   (cke),
    .sdram_wire_dqm   (dqm),
    .sdram_wire_dq    (dq),
    .err_valid        (err_valid),
    .err_code         (err_code),
    .err_sticky       (err_sticky)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic drv, input logic [15:0] d);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba       = b;
    addr     = a;
    dqm      = m;
    tb_dq_en = drv;
    tb_dq    = d;
    @(posedge clk);
    #1;
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    ba       = 2'd0;
    addr     = 13'd0;
    dqm      = 2'b00;
    tb_dq_en = 1'b0;
  endtask

  task automatic nop();                                issue(4'b0111, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0); endtask
  task automatic act(input logic [1:0] b, input logic [12:0] r); issue(4'b0011, b, r, 2'b00, 1'b0, 16'h0); endtask
  task automatic rd(input logic [1:0] b, input logic [12:0] a);  issue(4'b0101, b, a, 2'b00, 1'b0, 16'h0); endtask
  task automatic wr(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
    issue(4'b0100, b, a, m, 1'b1, d);
  endtask
  task automatic lmr(input logic [12:0] a);            issue(4'b0000, 2'd0, a, 2'b00, 1'b0, 16'h0); endtask
  task automatic pre(input logic [1:0] b, input logic [12:0] a); issue(4'b0010, b, a, 2'b00, 1'b0, 16'h0); endtask
  task automatic refresh();                            issue(4'b0001, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0); endtask

  // Advance to the falling edge after the next rising edge.
  task automatic slot();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cke   = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    ba = 2'd0; addr = 13'd0; dqm = 2'b00;
    tb_dq = 16'h0; tb_dq_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_err_valid",  16'(err_valid),  16'h0);
    chk("reset_err_code",   16'(err_code),   16'h0);
    chk("reset_err_sticky", 16'(err_sticky), 16'h0);
    chk("reset_dq_hiz",     dq,              HIZ);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read at CL=3, read issued the cycle after the write.
    lmr(13'h030);
    act(2'd1, 13'd5);
    nop();
    wr(2'd1, 13'd3, 16'hA5C3, 2'b00);
    rd(2'd1, 13'd3);
    @(negedge clk); chk("cl3_before_t1", dq, HIZ);
                    chk("cl3_no_err", 16'(err_valid), 16'h0);
    slot();         chk("cl3_before_t2", dq, HIZ);
    slot();         chk("cl3_data", dq, 16'hA5C3);
    slot();         chk("cl3_after", dq, HIZ);

    // CL=2.
    lmr(13'h020);
    rd(2'd1, 13'd3);
    @(negedge clk); chk("cl2_before_t1", dq, HIZ);
    slot();         chk("cl2_data", dq, 16'hA5C3);
    slot();         chk("cl2_after", dq, HIZ);

    // Write byte mask: dqm[1]=1 keeps the old upper byte.
    wr(2'd1, 13'd7, 16'hFFFF, 2'b00);
    wr(2'd1, 13'd7, 16'h1234, 2'b10);
    rd(2'd1, 13'd7);
    slot();         chk("wr_mask_data", dq, 16'hFF34);

    // Back-to-back reads at CL=3.
    lmr(13'h030);
    rd(2'd1, 13'd3);
    rd(2'd1, 13'd7);
    @(negedge clk); chk("b2b_before", dq, HIZ);
    slot();         chk("b2b_first", dq, 16'hA5C3);
    slot();         chk("b2b_second", dq, 16'hFF34);
    slot();         chk("b2b_after", dq, HIZ);

    // Read byte mask: dqm=01 one cycle after the READ masks the low byte.
    rd(2'd1, 13'd3);
    issue(4'b0111, 2'd0, 13'd0, 2'b01, 1'b0, 16'h0);
    @(negedge clk); chk("rd_mask_before", dq, HIZ);
    slot();         chk("rd_mask_data", dq, 16'hA5FF);

    // WRITE right after a READ cancels the read and reports a collision.
    rd(2'd1, 13'd3);
    wr(2'd1, 13'd9, 16'h0F0F, 2'b00);
    @(negedge clk); chk("collide_valid", 16'(err_valid), 16'h1);
                    chk("collide_code", 16'(err_code), 16'h7);
    slot();         chk("collide_dq_released", dq, HIZ);

    // Illegal mode fields: error 4, CL stays 3.
    lmr(13'h010);
    @(negedge clk); chk("bad_cl_code", 16'(err_code), 16'h4);
    lmr(13'h031);
    @(negedge clk); chk("bad_bl_code", 16'(err_code), 16'h4);
    rd(2'd1, 13'd3);
    @(negedge clk); chk("cl_kept_valid_low", 16'(err_valid), 16'h0);
    slot();         chk("cl_kept_before", dq, HIZ);
    slot();         chk("cl_kept_data", dq, 16'hA5C3);

    // ACTIVE to an open bank, refresh with a bank open.
    act(2'd1, 13'd5);
    @(negedge clk); chk("act_open_code", 16'(err_code), 16'h2);
    refresh();
    @(negedge clk); chk("ref_open_code", 16'(err_code), 16'h3);

    // READ to idle bank 2: error 1, nothing driven.
    rd(2'd2, 13'd0);
    @(negedge clk); chk("closed_valid", 16'(err_valid), 16'h1);
                    chk("closed_code", 16'(err_code), 16'h1);
                    chk("closed_sticky", 16'(err_sticky), 16'h1);
    slot();         chk("closed_before", dq, HIZ);
    slot();         chk("closed_no_drive", dq, HIZ);
                    chk("pulse_ended", 16'(err_valid), 16'h0);
                    chk("sticky_held", 16'(err_sticky), 16'h1);

    // tRCD: READ one cycle after ACTIVE.
    pre(2'd0, 13'h400);
    nop();
    nop();
    act(2'd0, 13'd1);
    rd(2'd0, 13'd0);
    @(negedge clk); chk("trcd_code", 16'(err_code), 16'(EXP_TRCD));

    // tRP: ACTIVE one cycle after PRECHARGE.
    nop();
    nop();
    nop();
    pre(2'd0, 13'h000);
    act(2'd0, 13'd1);
    @(negedge clk); chk("trp_code", 16'(err_code), 16'(EXP_TRP));
                    chk("sticky_final", 16'(err_sticky), 16'h1);

    // Reset during a CL=3 read.
    act(2'd1, 13'd5);
    nop();
    rd(2'd1, 13'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;             chk("rst_dq_released", dq, HIZ);
    @(negedge clk);
    rst_n = 1'b1;
    slot();         chk("rst_slot_hiz", dq, HIZ);
                    chk("rst_sticky_clear", 16'(err_sticky), 16'h0);
    @(posedge clk); #1;
    rd(2'd1, 13'd3);
    @(negedge clk); chk("rst_bank_idle", 16'(err_code), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
